// File: rtl/fsm1011_pkg.sv
// Shared types and constants for the 1011 pattern transmitter and its detector.
package fsm1011_pkg;

    typedef enum logic {IDLE, SEND} tx_state_t;

    localparam logic [3:0]  PATTERN_1011 = 4'b1011;
    localparam int unsigned DEF_MAX_LEN  = 32;
    localparam int unsigned DEF_REP_W    = 8;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm1011_bit_timer.sv
// Down-counter that stretches each transmitted bit over BIT_DIV clocks.
module fsm1011_bit_timer
    import fsm1011_pkg::*;
#(
    parameter int unsigned BIT_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    output logic first,
    output logic last
);

    localparam int unsigned   TW     = cnt_w(BIT_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(BIT_DIV - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= RELOAD;
        end else if (run) begin
            cnt <= (cnt == '0) ? RELOAD : cnt - TW'(1);
        end
    end

    assign first = run && (cnt == RELOAD);
    assign last  = run && (cnt == '0);

endmodule

// File: rtl/fsm1011_pattern_tx.sv
// Serial MSB-first pattern source for the 1011 detector, with repeat and bit stretching.
module fsm1011_pattern_tx
    import fsm1011_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned REP_W   = DEF_REP_W,
    parameter int unsigned BIT_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_pattern,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [REP_W-1:0]   load_rep,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               bit_strobe,
    output logic               busy,
    output logic               done
);

    tx_state_t          state, state_next;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q, idx, idx_next, eff_len;
    logic [REP_W-1:0]   pass_cnt, pass_next;
    logic               done_q, done_next;
    logic               load_en, timer_start, bit_last;

    assign eff_len = (load_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : load_len;

    fsm1011_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .run   (state == SEND),
        .first (bit_strobe),
        .last  (bit_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx      <= '0;
            pass_cnt <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            pass_cnt <= pass_next;
            done_q   <= done_next;
            if (load_en) begin
                pat_q <= load_pattern;
                len_q <= eff_len;
            end
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        pass_next   = pass_cnt;
        done_next   = 1'b0;
        load_en     = 1'b0;
        timer_start = 1'b0;
        case (state)
            IDLE: begin
                // abort is deliberately not looked at here: a load always wins in IDLE
                if (load_valid) begin
                    load_en = 1'b1;
                    if (eff_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next  = SEND;
                        idx_next    = eff_len - LEN_W'(1);
                        pass_next   = load_rep;
                        timer_start = 1'b1;
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (bit_last) begin
                    if (idx != '0) begin
                        idx_next = idx - LEN_W'(1);
                    end else if (pass_cnt != '0) begin
                        pass_next = pass_cnt - REP_W'(1);
                        idx_next  = len_q - LEN_W'(1);
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign x_valid    = (state == SEND);
    assign busy       = x_valid;
    assign load_ready = (state == IDLE);
    assign done       = done_q;
    assign x          = x_valid && |(pat_q & (MAX_LEN'(1) << idx));

endmodule

// File: tb/tb_fsm1011_pattern_tx.sv
// Directed bench for fsm1011_pattern_tx: one instance at BIT_DIV=1, one at BIT_DIV=3.
module tb_fsm1011_pattern_tx;
    import fsm1011_pkg::*;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
    localparam int unsigned REP_W   = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_load_valid, a_load_ready, a_abort;
    logic [MAX_LEN-1:0] a_load_pattern;
    logic [LEN_W-1:0]   a_load_len;
    logic [REP_W-1:0]   a_load_rep;
    logic               a_x, a_x_valid, a_bit_strobe, a_busy, a_done;

    logic               b_load_valid, b_load_ready, b_abort;
    logic [MAX_LEN-1:0] b_load_pattern;
    logic [LEN_W-1:0]   b_load_len;
    logic [REP_W-1:0]   b_load_rep;
    logic               b_x, b_x_valid, b_bit_strobe, b_busy, b_done;

    fsm1011_pattern_tx #(.MAX_LEN(MAX_LEN), .REP_W(REP_W), .BIT_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .load_valid(a_load_valid), .load_ready(a_load_ready),
        .load_pattern(a_load_pattern), .load_len(a_load_len), .load_rep(a_load_rep),
        .abort(a_abort), .x(a_x), .x_valid(a_x_valid), .bit_strobe(a_bit_strobe),
        .busy(a_busy), .done(a_done)
    );

    fsm1011_pattern_tx #(.MAX_LEN(MAX_LEN), .REP_W(REP_W), .BIT_DIV(3)) dut_b (
        .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_ready(b_load_ready),
        .load_pattern(b_load_pattern), .load_len(b_load_len), .load_rep(b_load_rep),
        .abort(b_abort), .x(b_x), .x_valid(b_x_valid), .bit_strobe(b_bit_strobe),
        .busy(b_busy), .done(b_done)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Output vectors ordered {x, x_valid, bit_strobe, busy, done, load_ready}
    logic [5:0] a_vec, b_vec;
    assign a_vec = {a_x, a_x_valid, a_bit_strobe, a_busy, a_done, a_load_ready};
    assign b_vec = {b_x, b_x_valid, b_bit_strobe, b_busy, b_done, b_load_ready};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [31:0] pat, input int unsigned len, input int unsigned rep);
        a_load_pattern = pat;
        a_load_len     = LEN_W'(len);
        a_load_rep     = REP_W'(rep);
        a_load_valid   = 1'b1;
        step();
        a_load_valid   = 1'b0;
    endtask

    initial begin
        logic [11:0] seq12;
        logic [3:0]  det;
        int unsigned hits, nbits, ones;
        logic        seen_done;

        rst = 1'b1;
        a_load_valid = 1'b0; a_abort = 1'b0; a_load_pattern = '0; a_load_len = '0; a_load_rep = '0;
        b_load_valid = 1'b0; b_abort = 1'b0; b_load_pattern = '0; b_load_len = '0; b_load_rep = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_a", 32'(a_vec), 32'b000001);
        check("reset_b", 32'(b_vec), 32'b000001);

        // Basic 1011, single pass
        load_a(32'hB, 4, 0);
        for (int i = 0; i < 4; i++) begin
            seq12 = 12'b1011;
            check($sformatf("basic_bit%0d", i), 32'(a_vec), {26'b0, seq12[3-i], 5'b11100});
            step();
        end
        check("basic_done", 32'(a_vec), 32'b000011);
        step();
        check("basic_idle", 32'(a_vec), 32'b000001);

        // Three passes into a 1011 detector model
        load_a(32'hB, 4, 2);
        seq12 = 12'b101110111011;
        det   = '0;
        hits  = 0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("rep_bit%0d", i), 32'(a_vec), {26'b0, seq12[11-i], 5'b11100});
            det = {det[2:0], a_x};
            if (a_x_valid && det == PATTERN_1011) hits++;
            step();
        end
        check("rep_done", 32'(a_vec), 32'b000011);
        check("rep_hits", hits, 3);
        step();

        // Stretched bits on the BIT_DIV=3 instance
        b_load_pattern = 32'b10;
        b_load_len     = LEN_W'(2);
        b_load_rep     = '0;
        b_load_valid   = 1'b1;
        step();
        b_load_valid   = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("div3_c%0d", c), 32'(b_vec),
                  {26'b0, (c <= 3), 1'b1, (c == 1 || c == 4), 3'b100});
            step();
        end
        check("div3_done", 32'(b_vec), 32'b000011);
        step();

        // Zero length: immediate done, nothing sent
        load_a(32'hFFFF_FFFF, 0, 0);
        check("len0_done", 32'(a_vec), 32'b000011);
        step();
        check("len0_idle", 32'(a_vec), 32'b000001);

        // Oversized length clamps to MAX_LEN
        load_a(32'hFFFF_FFFF, 40, 0);
        nbits = 0; ones = 0; seen_done = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            if (a_done) seen_done = 1'b1;
            else begin
                if (a_x_valid) nbits++;
                if (a_x) ones++;
                step();
            end
        end
        check("clamp_done_seen", 32'(seen_done), 1);
        check("clamp_bits", nbits, 32);
        check("clamp_ones", ones, 32);
        step();

        // Abort on the 3rd bit of an 8-bit transfer
        load_a(32'hFF, 8, 0);
        step();
        step();
        check("abort_bit3", 32'(a_vec), 32'b111100);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("abort_idle", 32'(a_vec), 32'b000001);
        step();
        check("abort_nodone", 32'(a_vec), 32'b000001);

        // Reset during SEND
        load_a(32'hFF, 8, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_send", 32'(a_vec), 32'b000001);

        // Load and abort together in IDLE: load wins, then completes normally
        a_abort = 1'b1;
        load_a(32'hB, 4, 0);
        a_abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq12 = 12'b1011;
            check($sformatf("post_bit%0d", i), 32'(a_vec), {26'b0, seq12[3-i], 5'b11100});
            step();
        end
        check("post_done", 32'(a_vec), 32'b000011);
        step();

        // load_valid held through SEND is ignored; accepted again in the done cycle
        a_load_pattern = 32'hB;
        a_load_len     = LEN_W'(4);
        a_load_rep     = '0;
        a_load_valid   = 1'b1;
        step();
        a_load_pattern = 32'h6;
        for (int i = 0; i < 4; i++) begin
            seq12 = 12'b1011;
            check($sformatf("hold_bit%0d", i), 32'(a_vec), {26'b0, seq12[3-i], 5'b11100});
            step();
        end
        check("hold_done", 32'(a_vec), 32'b000011);
        step();
        a_load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seq12 = 12'b0110;
            check($sformatf("b2b_bit%0d", i), 32'(a_vec), {26'b0, seq12[3-i], 5'b11100});
            step();
        end
        check("b2b_done", 32'(a_vec), 32'b000011);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fsm1011_pattern_tx.md
Name: fsm1011_pattern_tx

Overview:
Serial pattern transmitter, the stimulus end of the 1011 sequence-detector interface. It accepts a parallel bit pattern over a valid/ready load handshake and drives it MSB-first onto the detector's serial input `x`. It can repeat the pattern and stretch each bit over a programmable number of clocks. It replaces hand-timed `x` waveforms with a synthesizable, repeatable source usable in both bench and on-chip self-test.

Parameters:
- MAX_LEN, 32, maximum pattern length in bits.
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- REP_W, 8, width of the repeat-count field.
- BIT_DIV, 1, clocks each bit is held on `x` (legal range ≥1).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load request.
- load_ready  out  1  transmitter can accept a load.
- load_pattern  in  MAX_LEN  pattern bits; transmission starts at bit load_len-1.
- load_len  in  LEN_W  number of bits per pass.
- load_rep  in  REP_W  extra passes; total passes = load_rep+1.
- abort  in  1  synchronous cancel of the current transmission.
- x  out  1  serial data to the detector.
- x_valid  out  1  `x` carries a pattern bit.
- bit_strobe  out  1  one-cycle pulse on the first clock of every bit.
- busy  out  1  transmission in progress.
- done  out  1  one-cycle pulse when the final bit completes.

Behaviour:
- Reset (rst=1 at an edge): state IDLE.
  - x=0, x_valid=0, bit_strobe=0, busy=0, done=0, load_ready=1.
  - All counters and the shift register are cleared.
  - rst overrides abort and load.
- States are IDLE and SEND.
- load_ready=1 exactly when the state is IDLE. load_valid while not IDLE is ignored.
- Accept: load_valid & load_ready at edge k.
  - The block latches pattern, len and rep.
  - If load_len > MAX_LEN, len is clamped to MAX_LEN.
- len=0 at accept:
  - State stays IDLE and no bits are sent.
  - done=1 in cycle k+1.
- len>0 at accept: enter SEND.
  - In cycle k+1: x = pattern[len-1], x_valid=1, bit_strobe=1, busy=1.
- Each bit is held for exactly BIT_DIV cycles. bit_strobe is high only on the first cycle of each bit.
- Bit index decrements from len-1 to 0.
- At the end of a pass:
  - If passes remain, index reloads to len-1 with no idle gap and the pass counter decrements.
  - A bit-level stream of the same pattern results.
- Total SEND duration = len × BIT_DIV × (rep+1) cycles.
- Cycle after the last bit period:
  - State returns to IDLE, with done=1 for one cycle.
  - x=0, x_valid=0, busy=0, load_ready=1.
  - A load accepted in that same done cycle is legal; its first bit appears in the next cycle.
- abort=1 in SEND:
  - Next cycle the state is IDLE, with x=0, x_valid=0, busy=0.
  - No done pulse is issued.
  - abort in IDLE has no effect. abort and load_valid in the same IDLE cycle: the load is accepted and the abort is ignored.
- When x_valid=0, x is held at 0.
- Counters:
  - Bit-timer width is $clog2(BIT_DIV) (minimum 1).
  - The bit index uses LEN_W bits.
  - The pass counter uses REP_W bits.
  - No counter may wrap. Terminal compare is against 0.

Decomposition:
- fsm1011_pkg holds:
  - typedef enum logic {IDLE, SEND} tx_state_t.
  - localparam PATTERN_1011 = 4'b1011.
  - The shared interface width constants.
- Sub-module fsm1011_bit_timer is a BIT_DIV down-counter.
  - Inputs: clk, rst, start, run.
  - Outputs: first (= bit_strobe), last (end of bit period).
  - The top FSM instantiates it once.

Test Plan:
- BIT_DIV=1; load 1011, len=4, rep=0 at cycle 0 → cycles 1–4 give x=1,0,1,1 with x_valid=1 and bit_strobe every cycle; done=1 at cycle 5; load_ready=1 at cycle 5.
- len=4 pattern 1011, rep=2, driving the detector → x=101110111011 over cycles 1–12; done at cycle 13; detector output y pulses exactly 3 times.
- BIT_DIV=3; pattern 10, len=2 → x=1 for cycles 1–3 and x=0 for cycles 4–6; bit_strobe at cycles 1 and 4 only; done at cycle 7.
- len=0 → done at cycle 1; x_valid and busy never asserted. Then load_len=40 with all-ones pattern → exactly 32 bits sent.
- Mid-operation control:
  - abort at the 3rd bit of a len=8 transfer → IDLE next cycle, no done, x=0.
  - Separately, rst during SEND → all outputs at reset values next cycle.
  - A new load then completes normally.
- load_valid held high during SEND → ignored; a new load is accepted in the done cycle and its first bit follows with no gap.
